// File: rtl/seed_round_ctrl.sv
// seed_round_ctrl: buffers a 16-byte block, sequences 17 SEED round phases over the byte-serial datapath, and streams the result out.
module seed_round_ctrl #(
  parameter int PHASE_CYCLES = 24,
  parameter int PIPE_LAT     = 8,
  parameter int LAST_PHASE   = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] lr_in,
  input  logic [7:0] lr_out,
  output logic [4:0] main_counter,
  output logic       sk_rd,
  output logic [7:0] sk_addr,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       busy,
  output logic       done
);
  localparam int            CW       = $clog2(PHASE_CYCLES + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0] CAP_LO   = CW'(PIPE_LAT);
  localparam logic [CW-1:0] CAP_HI   = CW'(PIPE_LAT + 16);
  localparam logic [4:0]    MC_LAST  = 5'(LAST_PHASE);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_OUT} state_t;

  state_t        r_state, w_next;
  logic [3:0]    r_widx, r_ridx;
  logic [CW-1:0] r_cyc;
  logic [4:0]    r_mc;
  logic          r_done;
  logic [7:0]    r_ibuf [0:15];
  logic [7:0]    r_obuf [0:15];

  logic       w_in_acc, w_out_acc, w_cyc_wrap, w_run_end, w_cap;
  logic [3:0] w_cap_idx;

  assign w_in_acc   = r_state == S_LOAD && din_valid;
  assign w_out_acc  = r_state == S_OUT && dout_ready;
  assign w_cyc_wrap = r_cyc == CYC_LAST;
  assign w_run_end  = r_state == S_RUN && r_mc == MC_LAST && w_cyc_wrap;
  assign w_cap      = r_state == S_RUN && r_mc == MC_LAST && r_cyc >= CAP_LO && r_cyc < CAP_HI;
  assign w_cap_idx  = 4'(r_cyc - CAP_LO);

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = (din_valid && r_widx == 4'hF) ? S_RUN : S_LOAD;
      S_RUN:   w_next = w_run_end ? S_OUT : S_RUN;
      S_OUT:   w_next = (dout_ready && r_ridx == 4'hF) ? S_IDLE : S_OUT;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_comb begin
    busy         = r_state != S_IDLE;
    din_ready    = r_state == S_LOAD;
    main_counter = r_state == S_RUN ? r_mc : 5'd0;
    sk_rd        = r_state == S_RUN && r_cyc < CW'(8);
    sk_addr      = sk_rd ? {r_mc, r_cyc[2:0]} : 8'd0;
    // phase 0 injects the buffered block, later phases recirculate the datapath output
    lr_in        = r_state != S_RUN ? 8'd0 :
                   r_mc != 5'd0     ? lr_out :
                   r_cyc < CW'(16)  ? r_ibuf[r_cyc[3:0]] : 8'd0;
    dout_valid   = r_state == S_OUT;
    dout         = dout_valid ? r_obuf[r_ridx] : 8'd0;
    done         = r_done;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_widx <= '0;
      r_ridx <= '0;
      r_cyc  <= '0;
      r_mc   <= '0;
      r_done <= 1'b0;
    end else if (abort) begin
      r_widx <= '0;
      r_ridx <= '0;
      r_cyc  <= '0;
      r_mc   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_out_acc && r_ridx == 4'hF;
      if (w_in_acc) r_widx <= r_widx + 4'd1;
      if (w_out_acc) r_ridx <= r_ridx + 4'd1;
      if (w_run_end) r_ridx <= '0;
      if (r_state == S_RUN) begin
        r_cyc <= w_cyc_wrap ? '0 : r_cyc + CW'(1);
        if (w_cyc_wrap) r_mc <= w_run_end ? 5'd0 : r_mc + 5'd1;
      end
    end

  // buffers are deliberately not reset or cleared by abort
  always_ff @(posedge clk) begin
    if (!abort && w_in_acc) r_ibuf[r_widx] <= din;
    if (!abort && w_cap) r_obuf[w_cap_idx] <= lr_out;
  end
endmodule
